// File: rtl/hpu_seq.sv
// hpu_seq: per-job sequencer for the HPU stream datapath.
// Runs item-memory load then stream compute, with status and watchdog.
module hpu_seq #(
    parameter int ITEM_W = 16,
    parameter int ADDR_W = 20,
    parameter int TMO_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ITEM_W-1:0] cfg_item_last,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic [ADDR_W-1:0] cfg_addr_j,
    input  logic              cfg_skip_matw,
    input  logic              src_valid,
    input  logic              dst_valid,
    input  logic              dst_ready,
    input  logic              dst_last,
    output logic              matw,
    output logic              mat_we,
    output logic [ITEM_W-1:0] mat_a,
    output logic              run,
    output logic [ADDR_W-1:0] addr_i,
    output logic [ADDR_W-1:0] addr_j,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       beat_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MATW = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [ITEM_W-1:0] ITEM_ONE = ITEM_W'(1);
    localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);

    logic [1:0]        r_state;
    logic [ITEM_W-1:0] r_item_last;
    logic [ITEM_W-1:0] r_mat_a;
    logic [ADDR_W-1:0] r_addr_i;
    logic [ADDR_W-1:0] r_addr_j;
    logic [TMO_W-1:0]  r_wdog;
    logic [31:0]       r_beat_cnt;
    logic              r_matw;
    logic              r_run;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_hs;
    logic [TMO_W-1:0]  w_wdog_nxt;

    assign w_hs       = dst_valid & dst_ready;
    assign w_wdog_nxt = r_wdog + TMO_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_item_last <= '0;
            r_mat_a     <= '0;
            r_addr_i    <= '0;
            r_addr_j    <= '0;
            r_wdog      <= '0;
            r_beat_cnt  <= '0;
            r_matw      <= 1'b0;
            r_run       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else if (abort) begin
            // Abort outranks a same-cycle start; flags only move mid-job.
            if (r_busy) r_err <= 1'b1;
            r_state <= S_IDLE;
            r_matw  <= 1'b0;
            r_run   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_item_last <= cfg_item_last;
                        r_addr_i    <= cfg_addr_i;
                        r_addr_j    <= cfg_addr_j;
                        r_mat_a     <= '0;
                        r_wdog      <= '0;
                        r_beat_cnt  <= '0;
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                        r_busy      <= 1'b1;
                        if (cfg_skip_matw) begin
                            r_state <= S_RUN;
                            r_run   <= 1'b1;
                        end else begin
                            r_state <= S_MATW;
                            r_matw  <= 1'b1;
                        end
                    end
                end
                S_MATW: begin
                    if (src_valid) begin
                        if (r_mat_a == r_item_last) begin
                            r_state <= S_RUN;
                            r_matw  <= 1'b0;
                            r_run   <= 1'b1;
                        end else begin
                            r_mat_a <= r_mat_a + ITEM_ONE;
                        end
                    end
                end
                S_RUN: begin
                    if (w_hs) begin
                        r_beat_cnt <= r_beat_cnt + 32'd1;
                        r_wdog     <= '0;
                        if (dst_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_run   <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end else if (&w_wdog_nxt) begin
                        r_wdog  <= w_wdog_nxt;
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                        r_run   <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_wdog <= w_wdog_nxt;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign matw     = r_matw;
    assign mat_we   = r_matw & src_valid;
    assign mat_a    = r_mat_a;
    assign run      = r_run;
    assign addr_i   = r_addr_i;
    assign addr_j   = r_addr_j;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign beat_cnt = r_beat_cnt;

endmodule

// File: tb/tb_hpu_seq.sv
// tb_hpu_seq: directed scoreboard bench for the hpu_seq job sequencer.
// Runs with a 4-bit watchdog so the stall timeout is reachable.
module tb_hpu_seq;

    localparam int ITEM_W = 16;
    localparam int ADDR_W = 20;
    localparam int TMO_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ITEM_W-1:0] cfg_item_last = '0;
    logic [ADDR_W-1:0] cfg_addr_i = '0;
    logic [ADDR_W-1:0] cfg_addr_j = '0;
    logic              cfg_skip_matw = 1'b0;
    logic              src_valid = 1'b0;
    logic              dst_valid = 1'b0;
    logic              dst_ready = 1'b0;
    logic              dst_last = 1'b0;
    logic              matw;
    logic              mat_we;
    logic [ITEM_W-1:0] mat_a;
    logic              run;
    logic [ADDR_W-1:0] addr_i;
    logic [ADDR_W-1:0] addr_j;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       beat_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int sb[$];

    hpu_seq #(.ITEM_W(ITEM_W), .ADDR_W(ADDR_W), .TMO_W(TMO_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_item_last(cfg_item_last), .cfg_addr_i(cfg_addr_i),
        .cfg_addr_j(cfg_addr_j), .cfg_skip_matw(cfg_skip_matw),
        .src_valid(src_valid), .dst_valid(dst_valid),
        .dst_ready(dst_ready), .dst_last(dst_last),
        .matw(matw), .mat_we(mat_we), .mat_a(mat_a), .run(run),
        .addr_i(addr_i), .addr_j(addr_j), .busy(busy), .done(done),
        .err(err), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop the scoreboard head; an empty queue is itself a failure.
    task automatic sb_chk(input string tag, input logic [31:0] obs);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            chk(tag, obs, sb.pop_front());
        end
    endtask

    initial begin
        int wr;
        int nwe;
        int beats;
        bit matw_seen;

        // Reset state
        #12;
        chk("rst_matw", matw, 0);
        chk("rst_run", run, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mat_a", mat_a, 0);
        chk("rst_beat", beat_cnt, 0);
        rst = 1'b0;
        tick();

        // 1: 100-word load with src_valid held high
        cfg_item_last = 16'd99;
        cfg_addr_i = 20'h12345;
        cfg_addr_j = 20'h0abcd;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_addr_i = 20'h0;
        cfg_addr_j = 20'h0;
        chk("t1_matw", matw, 1);
        chk("t1_busy", busy, 1);
        chk("t1_addr_i", addr_i, 32'h12345);
        chk("t1_addr_j", addr_j, 32'h0abcd);
        src_valid = 1'b1;
        nwe = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            sb.push_back(c);
            if (mat_we) begin
                nwe++;
                sb_chk("t1_mat_a", mat_a);
            end
            chk("t1_run_lo", run, 0);
            tick();
        end
        src_valid = 1'b0;
        #1;
        chk("t1_we_cnt", nwe, 100);
        chk("t1_run", run, 1);
        chk("t1_matw_lo", matw, 0);
        chk("t1_mat_a_hold", mat_a, 99);
        sb.delete();
        dst_valid = 1'b1;
        dst_ready = 1'b1;
        dst_last = 1'b1;
        tick();
        dst_valid = 1'b0;
        dst_last = 1'b0;
        chk("t1_done", done, 1);
        chk("t1_beat", beat_cnt, 1);
        chk("t1_busy_lo", busy, 0);

        // 2: skip load, 8 beats with dst_ready toggling
        cfg_skip_matw = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_run", run, 1);
        chk("t2_done_clr", done, 0);
        chk("t2_beat_clr", beat_cnt, 0);
        beats = 0;
        matw_seen = 1'b0;
        for (int c = 0; c < 40 && beats < 8; c++) begin
            dst_valid = 1'b1;
            dst_ready = (c % 2 == 0);
            dst_last = (beats == 7);
            if (dst_ready) sb.push_back(beats + 1);
            tick();
            if (matw) matw_seen = 1'b1;
            if (dst_ready) begin
                beats++;
                sb_chk("t2_beat_step", beat_cnt);
            end
        end
        dst_valid = 1'b0;
        dst_ready = 1'b0;
        dst_last = 1'b0;
        chk("t2_matw_never", matw_seen, 0);
        chk("t2_beat", beat_cnt, 8);
        chk("t2_done", done, 1);
        chk("t2_busy", busy, 0);
        chk("t2_run_lo", run, 0);

        // 3: load with 3-cycle bubbles
        cfg_skip_matw = 1'b0;
        cfg_item_last = 16'd99;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr = 0;
        for (int c = 0; c < 500 && wr < 100; c++) begin
            src_valid = (c % 4 == 0);
            #1;
            chk("t3_mat_a", mat_a, wr);
            chk("t3_matw", matw, 1);
            if (src_valid) sb.push_back(wr);
            if (mat_we) sb_chk("t3_we_addr", mat_a);
            tick();
            if (src_valid) wr++;
        end
        src_valid = 1'b0;
        chk("t3_run", run, 1);
        chk("t3_matw_lo", matw, 0);
        chk("t3_mat_a_hold", mat_a, 99);

        // 4: abort in RUN after 3 beats
        dst_valid = 1'b1;
        dst_ready = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        dst_valid = 1'b0;
        dst_ready = 1'b0;
        chk("t4_beat3", beat_cnt, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_run", run, 0);
        chk("t4_busy", busy, 0);
        chk("t4_err", err, 1);
        chk("t4_done", done, 0);
        chk("t4_beat", beat_cnt, 3);
        cfg_skip_matw = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_err_clr", err, 0);
        chk("t4_restart_run", run, 1);

        // 5: start+abort in RUN, then repeated start in MATW
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("t5_abort_wins_busy", busy, 0);
        chk("t5_abort_wins_err", err, 1);
        cfg_skip_matw = 1'b0;
        cfg_item_last = 16'd9;
        cfg_addr_i = 20'h00777;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_matw", matw, 1);
        src_valid = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        chk("t5_mat_a3", mat_a, 3);
        start = 1'b1;
        cfg_skip_matw = 1'b1;
        cfg_addr_i = 20'hfffff;
        cfg_item_last = 16'd2;
        tick();
        start = 1'b0;
        chk("t5_restart_ign_matw", matw, 1);
        chk("t5_restart_ign_a", mat_a, 4);
        chk("t5_addr_stable", addr_i, 32'h00777);
        for (int c = 0; c < 5; c++) tick();
        chk("t5_still_matw", matw, 1);
        tick();
        src_valid = 1'b0;
        chk("t5_run", run, 1);
        chk("t5_mat_a9", mat_a, 9);

        // 6: watchdog with dst_ready held low
        dst_valid = 1'b1;
        for (int c = 0; c < 14; c++) tick();
        chk("t6_err_pre", err, 0);
        chk("t6_run_pre", run, 1);
        tick();
        dst_valid = 1'b0;
        chk("t6_err", err, 1);
        chk("t6_run", run, 0);
        chk("t6_busy", busy, 0);

        // 6b: asynchronous reset in the middle of a load
        cfg_skip_matw = 1'b0;
        cfg_item_last = 16'd99;
        cfg_addr_i = 20'h00042;
        start = 1'b1;
        tick();
        start = 1'b0;
        src_valid = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        chk("t6_pre_rst_a", mat_a, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_matw", matw, 0);
        chk("t6_rst_we", mat_we, 0);
        chk("t6_rst_mat_a", mat_a, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_addr_i", addr_i, 0);
        chk("t6_rst_err", err, 0);
        src_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hpu_seq.md
# hpu_seq

Job sequencer for the HPU stream datapath. It takes one host start command and runs the whole job: item-memory load (`matw` phase), then stream compute (`run` phase), until the last output beat is accepted. It replaces the free-running `matw`/`run` register bits and the hard-coded `addr_i`/`addr_j`/`random_num` values in the top level with latched, per-job configuration, and it reports busy, done, error and beat-count status to the AXI-Lite register file.

## Interface
- `ITEM_W`, default 16: width of the item-memory address and count.
- `ADDR_W`, default 20: width of `addr_i` and `addr_j`.
- `TMO_W`, default 24: width of the output-stall watchdog counter. Timeout fires after 2^TMO_W−1 idle cycles.

Ports (one clock; reset is asynchronous, active-high):
- `clk`  in  1  clock, same domain as the AXIS datapath.
- `rst`  in  1  asynchronous active-high reset.
- `start`  in  1  single-cycle job-start pulse from the register write.
- `abort`  in  1  single-cycle abort pulse.
- `cfg_item_last`  in  ITEM_W  index of the last item-memory word (number of words − 1).
- `cfg_addr_i`  in  ADDR_W  compute loop bound i, latched at start.
- `cfg_addr_j`  in  ADDR_W  n-gram bound j, latched at start.
- `cfg_skip_matw`  in  1  when 1, skip the item-memory load and go straight to the run phase.
- `src_valid`  in  1  AXIS slave TVALID.
- `dst_valid`  in  1  AXIS master TVALID.
- `dst_ready`  in  1  AXIS master TREADY.
- `dst_last`  in  1  AXIS master TLAST.
- `matw`  out  1  item-memory write phase active.
- `mat_we`  out  1  item-memory write strobe, equal to `matw & src_valid`.
- `mat_a`  out  ITEM_W  item-memory write address.
- `run`  out  1  compute/stream phase active.
- `addr_i`, `addr_j`  out  ADDR_W  latched configuration values.
- `busy`  out  1  job in progress.
- `done`  out  1  sticky flag: job completed normally.
- `err`  out  1  sticky flag: job aborted or timed out.
- `beat_cnt`  out  32  number of output beats accepted in the current job.

## Operation
- States: IDLE, MATW, RUN, DONE.
- IDLE or DONE with `start`=1:
  - Latch `cfg_*`.
  - Clear `done`, `err`, `beat_cnt`, `mat_a` and the watchdog.
  - Go to MATW, or to RUN if `cfg_skip_matw`=1.
- `start` in MATW or RUN is ignored.
- MATW:
  - `matw`=1.
  - Each cycle with `src_valid`=1 writes one word at `mat_a`.
  - If `mat_a`≠latched item_last, `mat_a` increments.
  - If `mat_a`=item_last, go to RUN. `mat_a` holds its value.
  - With no `src_valid`, hold state.
- RUN:
  - `run`=1.
  - Each cycle with `dst_valid & dst_ready`, `beat_cnt` increments (wraps at 2^32) and the watchdog clears.
  - A handshake with `dst_last`=1 sets `done` and goes to DONE.
  - Each cycle without a handshake, the watchdog increments. At all-ones, set `err` and go to IDLE.
- DONE: `run`=0, `busy`=0. Hold status until the next `start`.
- `abort` in any state:
  - Go to IDLE next cycle.
  - `matw`/`run` drop.
  - `err`=1 if a job was in progress. An abort in IDLE or DONE leaves the flags unchanged.
- Simultaneous `start` and `abort`: abort wins.
- `busy` = state ∈ {MATW, RUN}.
- `addr_i`/`addr_j` stay stable from start until the next start.

## Timing
- Reset values: all outputs 0; state IDLE.
- Reset mid-job takes effect immediately (asynchronous), so `matw`/`run` drop without waiting for a clock edge.
- All outputs are registered except `mat_we`, which is combinational from `matw` and `src_valid`.
- `start` at edge N → `matw` (or `run`) = 1 after edge N.
- Last item write at edge M: `matw`=0 and `run`=1 after edge M, with no gap cycle.
- Last output handshake at edge K: `done`=1, `run`=0, `busy`=0 after edge K.
- `beat_cnt` already includes the last beat at that point.
- Minimum job length with `cfg_item_last`=0: 1 MATW cycle, then RUN until the last beat.

## Test plan
1. Reset, `cfg_item_last`=99, `start`, `src_valid` held high → `mat_a` steps 0..99 over 100 cycles, 100 `mat_we` pulses, `run`=1 on cycle 101.
2. `cfg_skip_matw`=1, `start`, 8 dst beats with `dst_last` on the 8th, `dst_ready` toggling each cycle → `matw` never asserts, `beat_cnt`=8, `done`=1, `busy`=0.
3. `src_valid` with 3-cycle bubbles during MATW → `mat_a` advances only on valid cycles; the transition happens exactly on the 100th write.
4. `abort` in RUN after 3 beats → IDLE next cycle, `err`=1, `done`=0, `run`=0, `beat_cnt`=3; a following `start` clears `err`.
5. `start` repeated during MATW, and `start`+`abort` in the same cycle during RUN → repeated start ignored; abort wins.
6. `TMO_W`=4, RUN with `dst_ready`=0 → `err`=1 after 15 stall cycles; async `rst` mid-MATW → all outputs 0 immediately.
